// File: rtl/icache_data_array_arb.sv
// Single-port icache data array arbiter: hit reads vs. queued MSHR linefill writes.
// Reads win by default; a starvation limit, FIFO-full or a read-after-linefill hazard force a write.
module icache_data_array_arb #(
  parameter int INDEX_W    = 7,
  parameter int DATA_W     = 512,
  parameter int MSHR_IDX_W = 3,
  parameter int LF_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rd_vld,
  output logic                  o_rd_rdy,
  input  logic [INDEX_W-1:0]    i_rd_index,
  input  logic                  i_rd_way,
  output logic                  o_rd_resp_vld,
  output logic [DATA_W-1:0]     o_rd_resp_data,
  input  logic                  i_lf_vld,
  output logic                  o_lf_rdy,
  input  logic [INDEX_W-1:0]    i_lf_index,
  input  logic                  i_lf_way,
  input  logic [MSHR_IDX_W-1:0] i_lf_mshr_idx,
  input  logic [DATA_W-1:0]     i_lf_data,
  output logic                  o_lf_done,
  output logic [MSHR_IDX_W-1:0] o_lf_done_idx,
  output logic                  o_ram_en,
  output logic                  o_ram_wr_en,
  output logic [INDEX_W:0]      o_ram_addr,
  output logic [DATA_W-1:0]     o_ram_wdata,
  input  logic [DATA_W-1:0]     i_ram_rdata
);

  localparam int PTR_W = (LF_DEPTH > 1) ? $clog2(LF_DEPTH) : 1;
  localparam int CNT_W = $clog2(LF_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  logic [INDEX_W-1:0]    r_idx  [LF_DEPTH];
  logic                  r_way  [LF_DEPTH];
  logic [MSHR_IDX_W-1:0] r_mshr [LF_DEPTH];
  logic [DATA_W-1:0]     r_data [LF_DEPTH];
  logic [LF_DEPTH-1:0]   r_valid;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [STV_W-1:0]      r_starve;
  logic                  r_resp_vld;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_hazard;
  logic                  w_wg;
  logic [LF_DEPTH-1:0]   w_push_mask;
  logic [LF_DEPTH-1:0]   w_pop_mask;

  assign w_full   = (r_count == CNT_W'(LF_DEPTH));
  assign w_empty  = (r_count == '0);
  assign o_lf_rdy = !w_full;
  assign w_push   = i_lf_vld && !w_full;

  // A read must not overtake a queued or arriving linefill to the same {index, way}.
  // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < LF_DEPTH; i++) begin
      if (r_valid[i] && (r_idx[i] == i_rd_index) && (r_way[i] == i_rd_way)) w_hazard = 1'b1;
    end
    if (w_push && (i_lf_index == i_rd_index) && (i_lf_way == i_rd_way)) w_hazard = 1'b1;
  end

  assign w_wg = !w_empty && (!i_rd_vld || w_hazard || w_full || (r_starve == STV_W'(STARVE_MAX)));
  assign o_rd_rdy = i_rd_vld && !w_hazard && !w_wg;

  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_wr_en = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (w_wg) begin
      o_ram_en    = 1'b1;
      o_ram_wr_en = 1'b1;
      o_ram_addr  = {r_idx[r_rd_ptr], r_way[r_rd_ptr]};
      o_ram_wdata = r_data[r_rd_ptr];
    end else if (o_rd_rdy) begin
      o_ram_en    = 1'b1;
      o_ram_addr  = {i_rd_index, i_rd_way};
    end
  end

  assign o_lf_done      = w_wg;
  assign o_lf_done_idx  = w_wg ? r_mshr[r_rd_ptr] : '0;
  assign o_rd_resp_vld  = r_resp_vld;
  assign o_rd_resp_data = r_resp_vld ? i_ram_rdata : '0;

  assign w_push_mask = w_push ? (LF_DEPTH'(1) << r_wr_ptr) : '0;
  assign w_pop_mask  = w_wg   ? (LF_DEPTH'(1) << r_rd_ptr) : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_starve   <= '0;
      r_resp_vld <= 1'b0;
    end else begin
      r_valid    <= (r_valid | w_push_mask) & ~w_pop_mask;
      r_resp_vld <= o_rd_rdy;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_wg)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_wg})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_wg || w_empty)
        r_starve <= '0;
      else if (o_rd_rdy && (r_starve != STV_W'(STARVE_MAX)))
        r_starve <= r_starve + STV_W'(1);
    end
  end

  // NOTE: payload storage is not reset; r_valid and the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_idx[r_wr_ptr]  <= i_lf_index;
      r_way[r_wr_ptr]  <= i_lf_way;
      r_mshr[r_wr_ptr] <= i_lf_mshr_idx;
      r_data[r_wr_ptr] <= i_lf_data;
    end
  end

endmodule

// File: tb/tb_icache_data_array_arb.sv
// Directed bench for icache_data_array_arb: a cycle-by-cycle vector table plus
// hand-written hazard-wait and mid-operation reset sequences, against a behavioural RAM.
module tb_icache_data_array_arb;

  localparam int INDEX_W = 7;
  localparam int DATA_W  = 512;
  localparam int MI_W    = 3;
  localparam int NV      = 21;

  logic              clk;
  logic              rst;
  logic              rd_vld, rd_rdy, rd_way;
  logic [INDEX_W-1:0] rd_index;
  logic              rd_resp_vld;
  logic [DATA_W-1:0] rd_resp_data;
  logic              lf_vld, lf_rdy, lf_way;
  logic [INDEX_W-1:0] lf_index;
  logic [MI_W-1:0]   lf_mshr_idx;
  logic [DATA_W-1:0] lf_data;
  logic              lf_done;
  logic [MI_W-1:0]   lf_done_idx;
  logic              ram_en, ram_wr_en;
  logic [INDEX_W:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  icache_data_array_arb dut (
    .clk(clk), .rst(rst),
    .i_rd_vld(rd_vld), .o_rd_rdy(rd_rdy), .i_rd_index(rd_index), .i_rd_way(rd_way),
    .o_rd_resp_vld(rd_resp_vld), .o_rd_resp_data(rd_resp_data),
    .i_lf_vld(lf_vld), .o_lf_rdy(lf_rdy), .i_lf_index(lf_index), .i_lf_way(lf_way),
    .i_lf_mshr_idx(lf_mshr_idx), .i_lf_data(lf_data),
    .o_lf_done(lf_done), .o_lf_done_idx(lf_done_idx),
    .o_ram_en(ram_en), .o_ram_wr_en(ram_wr_en), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with 1-cycle read latency.
  logic [DATA_W-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    ram_rdata = '0;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr_en) mem[ram_addr] <= ram_wdata;
      else           ram_rdata     <= mem[ram_addr];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic             rd_vld;
    logic [6:0]       rd_index;
    logic             rd_way;
    logic             lf_vld;
    logic [6:0]       lf_index;
    logic             lf_way;
    logic [2:0]       lf_mshr;
    logic [7:0]       lf_tag;
    logic             e_rd_rdy;
    logic             e_lf_rdy;
    logic             e_ram_en;
    logic             e_wr;
    logic [7:0]       e_addr;
    logic [7:0]       e_wtag;
    logic             e_done;
    logic [2:0]       e_done_idx;
    logic             e_resp_vld;
    logic [7:0]       e_resp_tag;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t v(
    input logic rv, input logic [6:0] ri, input logic rw,
    input logic lv, input logic [6:0] li, input logic lw, input logic [2:0] lm, input logic [7:0] lt,
    input logic er, input logic el, input logic ee, input logic ew, input logic [7:0] ea,
    input logic [7:0] et, input logic ed, input logic [2:0] edi, input logic ev, input logic [7:0] ert);
    vec_t t;
    t.rd_vld = rv; t.rd_index = ri; t.rd_way = rw;
    t.lf_vld = lv; t.lf_index = li; t.lf_way = lw; t.lf_mshr = lm; t.lf_tag = lt;
    t.e_rd_rdy = er; t.e_lf_rdy = el; t.e_ram_en = ee; t.e_wr = ew; t.e_addr = ea;
    t.e_wtag = et; t.e_done = ed; t.e_done_idx = edi; t.e_resp_vld = ev; t.e_resp_tag = ert;
    return t;
  endfunction

  task automatic drive(input logic rv, input logic [6:0] ri, input logic rw,
                       input logic lv, input logic [6:0] li, input logic lw,
                       input logic [2:0] lm, input logic [7:0] lt);
    rd_vld = rv; rd_index = ri; rd_way = rw;
    lf_vld = lv; lf_index = li; lf_way = lw; lf_mshr_idx = lm; lf_data = {64{lt}};
  endtask

  initial begin
    logic seen_done;
    logic accepted;
    int   wait_cyc;

    // rd: vld idx way | lf: vld idx way mshr tag | exp: rd_rdy lf_rdy en wr addr wtag done didx resp resp_tag
    vecs[0]  = v(0,0,0, 1,5,1,2,8'hA1,  0,1,0,0,8'd0, 8'h00,0,0,0,8'h00); // idle push {5,1}
    vecs[1]  = v(0,0,0, 0,0,0,0,8'h00,  0,1,1,1,8'd11,8'hA1,1,2,0,8'h00); // drains at once
    vecs[2]  = v(0,0,0, 0,0,0,0,8'h00,  0,1,0,0,8'd0, 8'h00,0,0,0,8'h00);
    vecs[3]  = v(1,3,0, 1,20,0,1,8'hB2, 1,1,1,0,8'd6, 8'h00,0,0,0,8'h00); // read + push {20,0}
    vecs[4]  = v(1,3,0, 0,0,0,0,8'h00,  1,1,1,0,8'd6, 8'h00,0,0,1,8'h00); // starve 0->1
    vecs[5]  = v(1,3,0, 0,0,0,0,8'h00,  1,1,1,0,8'd6, 8'h00,0,0,1,8'h00); // 1->2
    vecs[6]  = v(1,3,0, 0,0,0,0,8'h00,  1,1,1,0,8'd6, 8'h00,0,0,1,8'h00); // 2->3
    vecs[7]  = v(1,3,0, 0,0,0,0,8'h00,  1,1,1,0,8'd6, 8'h00,0,0,1,8'h00); // 3->4
    vecs[8]  = v(1,3,0, 0,0,0,0,8'h00,  0,1,1,1,8'd40,8'hB2,1,1,1,8'h00); // forced write
    vecs[9]  = v(1,3,0, 0,0,0,0,8'h00,  1,1,1,0,8'd6, 8'h00,0,0,0,8'h00);
    vecs[10] = v(0,0,0, 0,0,0,0,8'h00,  0,1,0,0,8'd0, 8'h00,0,0,1,8'h00);
    vecs[11] = v(1,3,0, 1,10,1,3,8'hC3, 1,1,1,0,8'd6, 8'h00,0,0,0,8'h00); // fill 1st
    vecs[12] = v(1,3,0, 1,11,0,4,8'hD4, 1,1,1,0,8'd6, 8'h00,0,0,1,8'h00); // fill 2nd
    vecs[13] = v(1,3,0, 0,0,0,0,8'h00,  0,0,1,1,8'd21,8'hC3,1,3,1,8'h00); // full -> write
    vecs[14] = v(1,3,0, 0,0,0,0,8'h00,  1,1,1,0,8'd6, 8'h00,0,0,0,8'h00);
    vecs[15] = v(0,0,0, 0,0,0,0,8'h00,  0,1,1,1,8'd22,8'hD4,1,4,1,8'h00);
    vecs[16] = v(0,0,0, 0,0,0,0,8'h00,  0,1,0,0,8'd0, 8'h00,0,0,0,8'h00);
    vecs[17] = v(1,9,0, 1,9,0,5,8'hE5,  0,1,0,0,8'd0, 8'h00,0,0,0,8'h00); // hazard with push
    vecs[18] = v(1,9,0, 0,0,0,0,8'h00,  0,1,1,1,8'd18,8'hE5,1,5,0,8'h00); // hazard -> write
    vecs[19] = v(1,9,0, 0,0,0,0,8'h00,  1,1,1,0,8'd18,8'h00,0,0,0,8'h00); // read accepted
    vecs[20] = v(0,0,0, 0,0,0,0,8'h00,  0,1,0,0,8'd0, 8'h00,0,0,1,8'hE5); // new line returned

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_lf_rdy",   lf_rdy, 1);
    check("reset_rd_rdy",   rd_rdy, 0);
    check("reset_resp_vld", rd_resp_vld, 0);
    check("reset_lf_done",  lf_done, 0);
    check("reset_ram_en",   ram_en, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rd_vld, vecs[i].rd_index, vecs[i].rd_way, vecs[i].lf_vld,
            vecs[i].lf_index, vecs[i].lf_way, vecs[i].lf_mshr, vecs[i].lf_tag);
      #1;
      check($sformatf("v%0d_rd_rdy", i),      rd_rdy,       vecs[i].e_rd_rdy);
      check($sformatf("v%0d_lf_rdy", i),      lf_rdy,       vecs[i].e_lf_rdy);
      check($sformatf("v%0d_ram_en", i),      ram_en,       vecs[i].e_ram_en);
      check($sformatf("v%0d_ram_wr_en", i),   ram_wr_en,    vecs[i].e_wr);
      check($sformatf("v%0d_ram_addr", i),    ram_addr,     vecs[i].e_addr);
      check($sformatf("v%0d_lf_done", i),     lf_done,      vecs[i].e_done);
      check($sformatf("v%0d_lf_done_idx", i), lf_done_idx,  vecs[i].e_done_idx);
      check($sformatf("v%0d_resp_vld", i),    rd_resp_vld,  vecs[i].e_resp_vld);
      check($sformatf("v%0d_resp_data", i),   rd_resp_data, {64{vecs[i].e_resp_tag}});
      if (vecs[i].e_wr)
        check($sformatf("v%0d_ram_wdata", i), ram_wdata,    {64{vecs[i].e_wtag}});
    end

    // Read held on a line that is arriving: stalls until the write drains, then returns the new line.
    seen_done = 1'b0;
    accepted  = 1'b0;
    wait_cyc  = 0;
    for (int c = 0; c < 6 && !accepted; c++) begin
      @(negedge clk);
      if (c == 0) drive(1, 7'd12, 1, 1, 7'd12, 1, 3'd0, 8'h5A);
      else        drive(1, 7'd12, 1, 0, 7'd0, 0, 3'd0, 8'h00);
      #1;
      if (rd_rdy) accepted = 1'b1;
      else begin
        wait_cyc++;
        if (lf_done) seen_done = 1'b1;
      end
    end
    check("haz_accepted_in_budget", accepted, 1);
    check("haz_done_before_read", seen_done, 1);
    check("haz_stall_cycles", wait_cyc, 2);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
    #1;
    check("haz_resp_vld", rd_resp_vld, 1);
    check("haz_resp_data", rd_resp_data, {64{8'h5A}});

    // Reset with two queued linefills and a read response in flight.
    @(negedge clk);
    drive(1, 7'd1, 1, 1, 7'd30, 0, 3'd6, 8'h16);
    #1;
    check("rst_seq_read0", rd_rdy, 1);
    @(negedge clk);
    drive(1, 7'd1, 1, 1, 7'd31, 1, 3'd7, 8'h17);
    #1;
    check("rst_seq_read1", rd_rdy, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_seq_lf_rdy",   lf_rdy, 1);
    check("rst_seq_resp_vld", rd_resp_vld, 0);
    check("rst_seq_resp_data", rd_resp_data, '0);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      check($sformatf("rst_seq_no_done%0d", c), lf_done, 0);
      check($sformatf("rst_seq_no_ram%0d", c),  ram_en, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
